// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues {a, b, op} commands in a small FIFO and feeds them,
// one at a time, to an external combinational ALU. Each command is issued on
// registered operand lines, the ALU result is captured one cycle later and
// held behind a valid/ready handshake. A wrapping counter tracks completions.
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic [3:0] alu_in1,
    output logic [3:0] alu_in2,
    output logic [1:0] alu_sel,
    input  logic [3:0] alu_out1,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_zero,
    output logic       busy,
    output logic [7:0] ops_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // FIFO storage, one entry per command: {a, b, op}
    logic [9:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [9:0]    head;

    logic [1:0]    state;
    logic          rdy_en;
    logic          push;
    logic          pop;
    logic          res_hs;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign head       = mem[rd_ptr[AW-1:0]];

    // Readiness is derived only from registered state, so a pop on a full FIFO
    // cannot open a slot for a push in the same cycle.
    assign cmd_ready = rdy_en && !fifo_full;
    assign push      = cmd_valid && cmd_ready;

    // A pop needs a non-empty FIFO before the edge, so a push into an empty
    // FIFO is never consumed in the same cycle.
    assign res_hs = (state == S_RESP) && res_ready;
    assign pop    = !fifo_empty && ((state == S_IDLE) || res_hs);

    assign res_zero = (res_data == 4'h0);
    assign busy     = (state != S_IDLE) || !fifo_empty;

    // Hold cmd_ready low through reset and raise it on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // Write command payload into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    // Advance FIFO pointers on push and pop; they wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Sequencer FSM: issue operands, capture the ALU result, then hand it off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            alu_in1   <= 4'h0;
            alu_in2   <= 4'h0;
            alu_sel   <= 2'b00;
            res_valid <= 1'b0;
            res_data  <= 4'h0;
            ops_done  <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {alu_in1, alu_in2, alu_sel} <= head;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_data  <= alu_out1;
                    res_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        ops_done  <= ops_done + 8'd1;
                        res_valid <= 1'b0;
                        if (pop) begin
                            {alu_in1, alu_in2, alu_sel} <= head;
                            state <= S_EXEC;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: cmd_valid  input  1  command request.
REQ-005 Port: cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 Port: cmd_a  input  4  operand A.
REQ-007 Port: cmd_b  input  4  operand B.
REQ-008 Port: cmd_op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 XNOR.
REQ-009 Port: alu_in1  output  4  registered operand A to the downstream ALU.
REQ-010 Port: alu_in2  output  4  registered operand B to the downstream ALU.
REQ-011 Port: alu_sel  output  2  registered opcode to the downstream ALU.
REQ-012 Port: alu_out1  input  4  combinational ALU result.
REQ-013 Port: res_valid  output  1  result available.
REQ-014 Port: res_ready  input  1  result consumed when high with res_valid.
REQ-015 Port: res_data  output  4  captured result.
REQ-016 Port: res_zero  output  1  high when res_data is 4'h0.
REQ-017 Port: busy  output  1  high when state is not IDLE or the FIFO is non-empty.
REQ-018 Port: ops_done  output  8  completed-result count.

Function
REQ-019 The FIFO SHALL store {cmd_a, cmd_b, cmd_op} in order; push on cmd_valid && cmd_ready.
REQ-020 cmd_ready SHALL equal !full, using full as registered before the current edge; a pop on a full FIFO SHALL NOT enable a push in the same cycle.
REQ-021 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-022 IDLE: if the FIFO is non-empty, pop the head, load it into alu_in1/alu_in2/alu_sel, go to EXEC; otherwise stay.
REQ-023 EXEC: capture alu_out1 into res_data, set res_valid, go to RESP; this state SHALL last exactly one cycle.
REQ-024 RESP: hold res_valid and res_data stable until res_ready is sampled high.
REQ-025 RESP on handshake: increment ops_done, clear res_valid, then pop and load the next command and go to EXEC if the FIFO is non-empty, otherwise go to IDLE.
REQ-026 Latency:
- command pushed into an empty FIFO at edge N while in IDLE;
- operands appear on alu_* after edge N+1;
- res_valid is high after edge N+2.
REQ-027 Throughput SHALL be one result per 2 cycles with res_ready held high.
REQ-028 alu_in1/alu_in2/alu_sel SHALL change only on a pop and retain their last values otherwise, for power: no operand toggling while idle.
REQ-029 A push into an empty FIFO and a pop in the same cycle SHALL NOT occur; a pop requires non-empty before the edge.
REQ-030 ops_done SHALL wrap from 8'hFF to 8'h00.
REQ-031 Read and write pointers SHALL be log2(DEPTH)+1 bits:
- full when the MSBs differ and the low bits are equal;
- empty when all bits are equal;
- pointers wrap naturally.

Reset
REQ-032 While rst_n is low, independent of clk:
- state = IDLE; FIFO empty;
- alu_in1 = 0, alu_in2 = 0, alu_sel = 0;
- res_valid = 0, res_data = 0, ops_done = 0, busy = 0.
REQ-033 res_zero SHALL be 1 during reset, since res_data = 0.
REQ-034 cmd_ready SHALL be 0 while rst_n is low, and 1 from the first edge after release.
REQ-035 Reset asserted mid-operation SHALL discard all queued commands and any unconsumed result; no partial handshake survives.

Verification
REQ-036 Single op: push a=C, b=A, op=00 into idle block -> alu_in1=C, alu_in2=A, alu_sel=0 one cycle later; res_data=8, res_valid 2 cycles after push, res_zero=0.
REQ-037 Burst: push OR/XOR/XNOR of C,A back-to-back, res_ready=1 -> results E, 6, 9 in order, spaced 2 cycles, ops_done=3.
REQ-038 Backpressure: res_ready=0, push DEPTH+1 commands -> cmd_ready low once full; the first result is held stable; after res_ready=1 all results drain in order with none lost.
REQ-039 Zero result: a=5, b=A, op=00 -> res_data=0, res_zero=1.
REQ-040 Reset mid-op: assert rst_n low in RESP with 2 queued -> all outputs at reset values immediately; no result after release until a new push.
REQ-041 Wrap: complete 257 ops -> ops_done=8'h01.
